regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the 8x8 register file (IN/INADDRESS/WRITE) between two
//  requesters: port 0 (ALU writeback) and port 1 (data-memory load). Also provides a clear
//  sequencer that zeroes all registers one per cycle. Sits between the execute/memory stages
//  and reg_file. It drives the reg_file write inputs from registered outputs only.
// PARAMETERS
//  DW        8   data width
//  AW        3   register address width
//  NREG      8   registers walked by clear (2**AW)
//  CLR_VALUE 0   value written to each register by clear
// PORTS
//  CLK       in   1   clock, rising edge
//  RESET     in   1   synchronous, active-low reset
//  REQ0      in   1   port 0 write request (level, held until granted)
//  ADDR0     in   AW  port 0 destination register
//  DATA0     in   DW  port 0 write data
//  GNT0      out  1   port 0 grant (combinational)
//  REQ1      in   1   port 1 write request
//  ADDR1     in   AW  port 1 destination register
//  DATA1     in   DW  port 1 write data
//  GNT1      out  1   port 1 grant (combinational)
//  CLR_REQ   in   1   start clear sequence (sampled in ARB only)
//  CLR_BUSY  out  1   high while in CLEAR state
//  CLR_DONE  out  1   one-cycle pulse after the last clear write
//  WRITE     out  1   to reg_file WRITE (registered)
//  INADDRESS out  AW  to reg_file INADDRESS (registered)
//  IN        out  DW  to reg_file IN (registered)
// BEHAVIOUR
//  - Reset (RESET==0 at posedge): state=ARB, cnt=0, last=1, WRITE=0, INADDRESS=0, IN=0,
//    CLR_BUSY=0, CLR_DONE=0. GNT0 and GNT1 are 0 while RESET is low.
//    Reset mid-CLEAR aborts the sequence. No CLR_DONE pulse is issued for an aborted clear.
//  - States: ARB, CLEAR. ARB->CLEAR when CLR_REQ=1 at a posedge. CLEAR->ARB after the
//    write with cnt==NREG-1.
//  - Handshake: a transfer occurs at a posedge where REQx&&GNTx. The requester may change
//    ADDR/DATA or drop REQ in the following cycle. Holding REQ high requests another write.
//  - Grant (ARB, CLR_REQ==0):
//    - Only one request high: that request is granted.
//    - Both high: the port not granted last wins.
//    - last is updated on every transfer. After reset, port 0 wins the first tie.
//    - At most one GNT is high in any cycle.
//  - CLR_REQ=1 in ARB forces GNT0=GNT1=0 that cycle, so clear has priority over writes.
//  - Latency: a transfer at edge N gives WRITE=1, INADDRESS=ADDRx, IN=DATAx during cycle
//    N..N+1. reg_file commits it at edge N+1. WRITE=0 in any ARB cycle without a transfer.
//  - CLEAR: NREG cycles. The cycle after entry has WRITE=1, INADDRESS=cnt, IN=CLR_VALUE.
//    cnt counts 0..NREG-1. CLR_BUSY=1 for those NREG cycles and GNT0=GNT1=0 throughout.
//    CLR_DONE=1 in the first ARB cycle after the sequence. cnt returns to 0.
//  - CLR_REQ is ignored during CLEAR. If still high in the first ARB cycle, a new clear starts.
//  - Same-address write by both ports: serialised by the arbiter. The later grant wins in
//    reg_file. There is no merging.
//  - cnt is AW+1 bits wide so the end compare does not wrap. The address output is cnt[AW-1:0].
// STRUCTURE
//  - Shared package regfile_pkg: DW, AW, NREG, state encoding (ARB=1'b0, CLEAR=1'b1),
//    CLR_VALUE.
//  - Sub-module rr_arbiter2: 2-way round-robin arbiter (req[1:0], en, last -> gnt[1:0]),
//    combinational.
//  - The top holds the FSM, the clear counter, the last-grant register and the output registers.
// TESTING
//  1. Reset: hold RESET=0 for 2 edges with REQ0=1 -> GNT0=0, WRITE=0, INADDRESS=0, IN=0,
//     CLR_BUSY=0.
//  2. Single: REQ0=1, ADDR0=1, DATA0=12 for one transfer -> GNT0=1 that cycle.
//     Next cycle WRITE=1, INADDRESS=1, IN=12. A reg_file readback of r1 gives 12.
//  3. Tie: REQ0 and REQ1 held high (ADDR0=2, DATA0=93, ADDR1=7, DATA1=23) for 4 cycles ->
//     grants alternate 0,1,0,1. WRITE stays high for 4 cycles with addresses 2,7,2,7.
//  4. Clear: preload r1=50, pulse CLR_REQ with REQ1 pending ->
//     - GNT1=0 for 9 cycles;
//     - WRITE high for 8 cycles with INADDRESS 0..7 and IN=0;
//     - CLR_BUSY high for 8 cycles, then CLR_DONE for 1 cycle;
//     - GNT1 arrives after that; r1 reads 0 before the pending write lands.
//  5. Abort: assert RESET=0 at cnt=3 -> next cycle WRITE=0 and CLR_BUSY=0, no CLR_DONE.
//     r4..r7 keep their values.
//  6. Back-to-back: REQ1 held for 3 transfers with DATA1 35,36,37 -> 3 consecutive WRITE
//     cycles carry IN=35,36,37.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared parameters, state encoding and write-beat type for the register-file write arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package regfile_pkg;

    localparam int DW   = 8;          // register data width
    localparam int AW   = 3;          // register address width
    localparam int NREG = 1 << AW;    // registers walked by the clear sequence

    localparam logic [DW-1:0] CLR_VALUE = '0;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One write beat towards reg_file.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the port not granted last.
// Latency: combinational, zero cycles.
// Backpressure: en=0 withholds both grants; requesters simply keep their request level.
//
// Ports:
//   req[1:0]  request per port
//   en        grants allowed this cycle
//   last      port that received the most recent grant
//   gnt[1:0]  one-hot (or zero) grant
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single reg_file write port between ALU writeback (port 0) and memory load (port 1),
// plus a clear sequencer that writes CLR_VALUE to every register, one per cycle.
// Latency: a grant at edge N drives WRITE/INADDRESS/IN during cycle N..N+1 (registered outputs).
// Backpressure: requests are levels held until GNTx; grants are withheld during a clear and in
// the cycle CLR_REQ is seen, so clear always has priority over writes.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-low reset
//   REQ0/ADDR0/DATA0/GNT0 port 0 write request, destination, data, grant
//   REQ1/ADDR1/DATA1/GNT1 port 1 write request, destination, data, grant
//   CLR_REQ               start a clear sequence (only looked at while arbitrating)
//   CLR_BUSY, CLR_DONE    clear in progress, one-cycle pulse after the last clear write
//   WRITE/INADDRESS/IN    registered drive of the reg_file write port
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic [AW-1:0] ADDR0,
    input  logic [DW-1:0] DATA0,
    output logic          GNT0,
    input  logic          REQ1,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] DATA1,
    output logic          GNT1,
    input  logic          CLR_REQ,
    output logic          CLR_BUSY,
    output logic          CLR_DONE,
    output logic          WRITE,
    output logic [AW-1:0] INADDRESS,
    output logic [DW-1:0] IN
);

    state_t       state, state_nxt;
    // One bit wider than the address so the end-of-walk compare never wraps.
    logic [AW:0]  cnt, cnt_nxt;
    logic         last, last_nxt;
    logic         write_nxt;
    logic         done_nxt;
    wr_t          wr_nxt;
    logic         arb_en;
    logic [1:0]   gnt;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG - 1);

    // Grants only in ARB, out of reset, and not in the cycle a clear is being requested.
    assign arb_en = RESET && (state == ARB) && !CLR_REQ;

    rr_arbiter2 u_rr (
        .req  ({REQ1, REQ0}),
        .en   (arb_en),
        .last (last),
        .gnt  (gnt)
    );

    assign GNT0     = gnt[0];
    assign GNT1     = gnt[1];
    assign CLR_BUSY = (state == CLEAR);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_nxt    = last;
        write_nxt   = 1'b0;
        done_nxt    = 1'b0;
        // Address/data hold their last value when nothing is written.
        wr_nxt.addr = INADDRESS;
        wr_nxt.dat  = IN;

        case (state)
            ARB: begin
                if (CLR_REQ) begin
                    // First clear write goes out in the first CLEAR cycle.
                    state_nxt   = CLEAR;
                    cnt_nxt     = '0;
                    write_nxt   = 1'b1;
                    wr_nxt.addr = '0;
                    wr_nxt.dat  = CLR_VALUE;
                end else if (gnt[0]) begin
                    write_nxt   = 1'b1;
                    wr_nxt.addr = ADDR0;
                    wr_nxt.dat  = DATA0;
                    last_nxt    = 1'b0;
                end else if (gnt[1]) begin
                    write_nxt   = 1'b1;
                    wr_nxt.addr = ADDR1;
                    wr_nxt.dat  = DATA1;
                    last_nxt    = 1'b1;
                end
            end
            CLEAR: begin
                // cnt names the register being written during this cycle.
                if (cnt == CNT_LAST) begin
                    state_nxt = ARB;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt     = cnt + 1'b1;
                    write_nxt   = 1'b1;
                    wr_nxt.addr = cnt_nxt[AW-1:0];
                    wr_nxt.dat  = CLR_VALUE;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ARB;
            cnt       <= '0;
            last      <= 1'b1;
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
            CLR_DONE  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            WRITE     <= write_nxt;
            INADDRESS <= wr_nxt.addr;
            IN        <= wr_nxt.dat;
            CLR_DONE  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model and a shadow register file.
// Latency/backpressure: follows the DUT; inputs change 2ns after each rising edge.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic          CLK     = 1'b0;
    logic          RESET   = 1'b0;
    logic          REQ0    = 1'b0;
    logic          REQ1    = 1'b0;
    logic          CLR_REQ = 1'b0;
    logic [AW-1:0] ADDR0   = '0;
    logic [AW-1:0] ADDR1   = '0;
    logic [DW-1:0] DATA0   = '0;
    logic [DW-1:0] DATA1   = '0;
    logic          GNT0, GNT1, CLR_BUSY, CLR_DONE, WRITE;
    logic [AW-1:0] INADDRESS;
    logic [DW-1:0] IN;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    regfile_write_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ0      (REQ0),
        .ADDR0     (ADDR0),
        .DATA0     (DATA0),
        .GNT0      (GNT0),
        .REQ1      (REQ1),
        .ADDR1     (ADDR1),
        .DATA1     (DATA1),
        .GNT1      (GNT1),
        .CLR_REQ   (CLR_REQ),
        .CLR_BUSY  (CLR_BUSY),
        .CLR_DONE  (CLR_DONE),
        .WRITE     (WRITE),
        .INADDRESS (INADDRESS),
        .IN        (IN)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    // ---------------- reference model ----------------
    // The model tracks: whether a clear is running, the registers still to be cleared
    // (a queue), which port won last, and the write that must appear next cycle.
    bit m_valid    = 1'b0;
    bit m_clearing = 1'b0;
    int clr_q[$];
    int m_last     = 1;
    bit e_write    = 1'b0;
    bit e_done     = 1'b0;
    int e_addr     = 0;
    int e_data     = 0;
    int exp_rf[NREG];
    int dut_rf[NREG];

    initial begin
        bit eg0, eg1;
        for (int r = 0; r < NREG; r++) begin
            exp_rf[r] = 0;
            dut_rf[r] = 0;
        end
        forever begin
            @(negedge CLK);
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (RESET && m_valid && !m_clearing && !CLR_REQ) begin
                if (REQ0 && REQ1) begin
                    if (m_last == 1) eg0 = 1'b1;
                    else             eg1 = 1'b1;
                end else begin
                    eg0 = REQ0;
                    eg1 = REQ1;
                end
            end
            if (!RESET || m_valid) begin
                chk("m_gnt0", 32'(GNT0), 32'(eg0));
                chk("m_gnt1", 32'(GNT1), 32'(eg1));
            end
            if (m_valid) begin
                chk("m_write", 32'(WRITE), 32'(e_write));
                chk("m_busy", 32'(CLR_BUSY), 32'(m_clearing));
                chk("m_done", 32'(CLR_DONE), 32'(e_done));
                if (e_write) begin
                    chk("m_addr", 32'(INADDRESS), e_addr);
                    chk("m_data", 32'(IN), e_data);
                    exp_rf[e_addr] = e_data;
                end
            end
            // Shadow reg_file: commits whatever the DUT drives at the coming edge.
            if (WRITE === 1'b1) dut_rf[INADDRESS] = int'(IN);

            // Advance the model across the coming rising edge.
            if (!RESET) begin
                clr_q.delete();
                m_clearing = 1'b0;
                m_last     = 1;
                e_write    = 1'b0;
                e_done     = 1'b0;
                e_addr     = 0;
                e_data     = 0;
                m_valid    = 1'b1;
            end else if (m_clearing) begin
                e_done = 1'b0;
                if (clr_q.size() > 0) begin
                    e_write = 1'b1;
                    e_addr  = clr_q.pop_front();
                    e_data  = int'(CLR_VALUE);
                end else begin
                    m_clearing = 1'b0;
                    e_write    = 1'b0;
                    e_done     = 1'b1;
                end
            end else begin
                e_done = 1'b0;
                if (CLR_REQ) begin
                    for (int r = 0; r < NREG; r++) clr_q.push_back(r);
                    m_clearing = 1'b1;
                    e_write    = 1'b1;
                    e_addr     = clr_q.pop_front();
                    e_data     = int'(CLR_VALUE);
                end else if (eg0) begin
                    e_write = 1'b1;
                    e_addr  = int'(ADDR0);
                    e_data  = int'(DATA0);
                    m_last  = 0;
                end else if (eg1) begin
                    e_write = 1'b1;
                    e_addr  = int'(ADDR1);
                    e_data  = int'(DATA1);
                    m_last  = 1;
                end else begin
                    e_write = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        bit found;

        // Reset held for two edges with a pending request.
        RESET = 1'b0; REQ0 = 1'b1; ADDR0 = 3'd1; DATA0 = 8'd12;
        cyc(); cyc(); #1;
        chk("rst_gnt0", 32'(GNT0), 0);
        chk("rst_write", 32'(WRITE), 0);
        chk("rst_inaddr", 32'(INADDRESS), 0);
        chk("rst_in", 32'(IN), 0);
        chk("rst_busy", 32'(CLR_BUSY), 0);
        chk("rst_done", 32'(CLR_DONE), 0);

        // Single transfer on port 0.
        cyc(); RESET = 1'b1; #1;
        chk("single_gnt0", 32'(GNT0), 1);
        chk("single_gnt1", 32'(GNT1), 0);
        cyc(); REQ0 = 1'b0; #1;
        chk("single_write", 32'(WRITE), 1);
        chk("single_addr", 32'(INADDRESS), 1);
        chk("single_data", 32'(IN), 12);
        cyc(); #1;
        chk("single_idle", 32'(WRITE), 0);
        chk("single_rf1", dut_rf[1], 12);
        chk("model_rf1", exp_rf[1], 12);

        // Tie: fresh reset so port 0 wins first, then strict alternation.
        RESET = 1'b0;
        cyc();
        RESET = 1'b1;
        REQ0 = 1'b1; ADDR0 = 3'd2; DATA0 = 8'd93;
        REQ1 = 1'b1; ADDR1 = 3'd7; DATA1 = 8'd23;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_gnt0", 32'(GNT0), (i % 2 == 0) ? 1 : 0);
            chk("tie_gnt1", 32'(GNT1), (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                chk("tie_write", 32'(WRITE), 1);
                chk("tie_addr", 32'(INADDRESS), ((i - 1) % 2 == 0) ? 2 : 7);
                chk("tie_data", 32'(IN), ((i - 1) % 2 == 0) ? 93 : 23);
            end
            cyc();
        end
        REQ0 = 1'b0; REQ1 = 1'b0; #1;
        chk("tie_write_last", 32'(WRITE), 1);
        chk("tie_addr_last", 32'(INADDRESS), 7);
        cyc(); #1;
        chk("tie_idle", 32'(WRITE), 0);

        // Clear with a pending port-1 write: preload r1=50 first.
        REQ1 = 1'b1; ADDR1 = 3'd1; DATA1 = 8'd50; #1;
        chk("pre_gnt1", 32'(GNT1), 1);
        cyc(); CLR_REQ = 1'b1; ADDR1 = 3'd5; DATA1 = 8'd66; #1;
        chk("clrreq_gnt1", 32'(GNT1), 0);
        chk("pre_write_addr", 32'(INADDRESS), 1);
        cyc(); CLR_REQ = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            #1;
            chk("clr_gnt1", 32'(GNT1), 0);
            chk("clr_busy", 32'(CLR_BUSY), 1);
            chk("clr_write", 32'(WRITE), 1);
            chk("clr_addr", 32'(INADDRESS), k);
            chk("clr_data", 32'(IN), 0);
            chk("clr_nodone", 32'(CLR_DONE), 0);
            if (k == 0) chk("pre_rf1", dut_rf[1], 50);
            cyc();
        end
        #1;
        chk("clr_done", 32'(CLR_DONE), 1);
        chk("clr_busy_end", 32'(CLR_BUSY), 0);
        chk("clr_write_end", 32'(WRITE), 0);
        chk("post_gnt1", 32'(GNT1), 1);
        chk("clr_rf1", dut_rf[1], 0);
        cyc(); REQ1 = 1'b0; #1;
        chk("post_write", 32'(WRITE), 1);
        chk("post_addr", 32'(INADDRESS), 5);
        chk("post_data", 32'(IN), 66);
        chk("post_done_pulse", 32'(CLR_DONE), 0);
        cyc();

        // Abort: preload r4..r7, start a clear, reset while cnt==3.
        REQ0 = 1'b1;
        for (int j = 4; j < 8; j++) begin
            ADDR0 = AW'(j); DATA0 = DW'(100 + j); #1;
            chk("abort_pre_gnt0", 32'(GNT0), 1);
            cyc();
        end
        REQ0 = 1'b0;
        cyc();
        CLR_REQ = 1'b1;
        cyc();
        CLR_REQ = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            #1;
            if (CLR_BUSY && WRITE && INADDRESS == 3'd3) found = 1'b1;
            else cyc();
        end
        chk("abort_reach_cnt3", 32'(found), 1);
        RESET = 1'b0;
        cyc(); RESET = 1'b1; #1;
        chk("abort_write", 32'(WRITE), 0);
        chk("abort_busy", 32'(CLR_BUSY), 0);
        chk("abort_nodone0", 32'(CLR_DONE), 0);
        for (int t = 0; t < 3; t++) begin
            cyc(); #1;
            chk("abort_nodone", 32'(CLR_DONE), 0);
        end
        chk("abort_rf3", dut_rf[3], 0);
        for (int j = 4; j < 8; j++) chk("abort_keep", dut_rf[j], 100 + j);

        // Back-to-back on port 1.
        REQ1 = 1'b1; ADDR1 = 3'd6; DATA1 = 8'd35; #1;
        chk("b2b_gnt1", 32'(GNT1), 1);
        cyc(); DATA1 = 8'd36; #1;
        chk("b2b_w1", 32'(WRITE), 1);
        chk("b2b_d1", 32'(IN), 35);
        cyc(); DATA1 = 8'd37; #1;
        chk("b2b_w2", 32'(WRITE), 1);
        chk("b2b_d2", 32'(IN), 36);
        cyc(); REQ1 = 1'b0; #1;
        chk("b2b_w3", 32'(WRITE), 1);
        chk("b2b_d3", 32'(IN), 37);
        cyc(); #1;
        chk("b2b_idle", 32'(WRITE), 0);

        // Randomized traffic, occasional clears and resets; model checks every cycle.
        for (int n = 0; n < 2000; n++) begin
            cyc();
            REQ0    = 1'($urandom_range(0, 1));
            REQ1    = 1'($urandom_range(0, 1));
            ADDR0   = AW'($urandom);
            ADDR1   = AW'($urandom);
            DATA0   = DW'($urandom);
            DATA1   = DW'($urandom);
            CLR_REQ = ($urandom_range(0, 39) == 0);
            RESET   = ($urandom_range(0, 199) != 0);
        end
        cyc();
        REQ0 = 1'b0; REQ1 = 1'b0; CLR_REQ = 1'b0; RESET = 1'b1;
        repeat (12) cyc();
        #1;
        for (int r = 0; r < NREG; r++) chk("rand_rf", dut_rf[r], exp_rf[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
